// File: rtl/matmul_result_reader_pkg.sv
// Shared types, index-width helpers and the element extractor for the
// matmul result read-back path.
package matmul_result_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Upper bounds on what extract_elem can handle.
   localparam int unsigned MAX_ROW_BITS  = 1024;
   localparam int unsigned MAX_ELEM_BITS = 64;

   // Default geometry.
   localparam int unsigned DEF_ROWS               = 4;
   localparam int unsigned DEF_COLS               = 4;
   localparam int unsigned DEF_WORD_SIZE          = 8;
   localparam int unsigned DEF_MEM_PORT_WIDTH     = 32;
   localparam int unsigned DEF_MEM_ACCESS_LATENCY = 2;

   // Width of an index in 0..n-1, never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

   // Width of a counter that must hold the value n itself.
   function automatic int unsigned cnt_width(input int unsigned n);
      return unsigned'($clog2(n + 1));
   endfunction

   localparam int unsigned DEF_ROW_IDX_W = idx_width(DEF_ROWS);
   localparam int unsigned DEF_COL_IDX_W = idx_width(DEF_COLS);

   // Element 'col' of a row word packed little-end first, 'width' bits each.
   function automatic logic [MAX_ELEM_BITS-1:0] extract_elem(
      input logic [MAX_ROW_BITS-1:0] row,
      input int unsigned             col,
      input int unsigned             width
   );
      logic [MAX_ROW_BITS-1:0]  shifted;
      logic [MAX_ELEM_BITS-1:0] mask;
      shifted = row >> (col * width);
      mask    = (width >= MAX_ELEM_BITS) ? '1
              : ((MAX_ELEM_BITS'(1) << width) - MAX_ELEM_BITS'(1));
      return shifted[MAX_ELEM_BITS-1:0] & mask;
   endfunction

endpackage

// File: rtl/matmul_result_reader_result_row_fifo.sv
// Synchronous row FIFO; push and pop in one cycle are both honoured.
module result_row_fifo
   import matmul_result_reader_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic [WIDTH-1:0]            din,
   output logic [WIDTH-1:0]            dout,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic                        empty,
   output logic                        full
);
   localparam int unsigned PW = idx_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Accept/advance decisions and next pointer/count values.
   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   // Row storage; contents are only meaningful below the count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/matmul_result_reader.sv
// Reads a finished ROWS x COLS result matrix out of the output RAM and
// streams it one element per beat with row/col tags.
module matmul_result_reader
   import matmul_result_reader_pkg::*;
#(
   parameter int unsigned ROWS               = DEF_ROWS,
   parameter int unsigned COLS               = DEF_COLS,
   parameter int unsigned WORD_SIZE          = DEF_WORD_SIZE,
   parameter int unsigned MEM_PORT_WIDTH     = DEF_MEM_PORT_WIDTH,
   parameter int unsigned MEM_ACCESS_LATENCY = DEF_MEM_ACCESS_LATENCY,
   parameter int unsigned FIFO_DEPTH         = MEM_ACCESS_LATENCY + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [31:0]                   base_addr,
   output logic                          busy,
   output logic                          done,
   output logic [31:0]                   mem_addr,
   output logic                          mem_rd_en,
   input  logic [MEM_PORT_WIDTH-1:0]     mem_rd_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WORD_SIZE-1:0]          out_data,
   output logic [idx_width(ROWS)-1:0]    out_row,
   output logic [idx_width(COLS)-1:0]    out_col,
   output logic                          out_last
);
   localparam int unsigned ROW_BITS = COLS * WORD_SIZE;
   localparam int unsigned RW       = idx_width(ROWS);
   localparam int unsigned CLW      = idx_width(COLS);
   localparam int unsigned ISSUE_W  = cnt_width(ROWS);
   localparam int unsigned CNT_W    = cnt_width(FIFO_DEPTH);
   localparam int unsigned LAT      = MEM_ACCESS_LATENCY;

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic                 rd_en_q, rd_en_d;
   logic [31:0]          addr_q, addr_d, base_q, base_d;
   logic [ISSUE_W-1:0]   rd_row_q, rd_row_d;
   logic [CNT_W-1:0]     in_flight_q, in_flight_d;
   logic [LAT-1:0]       pipe_q, pipe_d;
   logic [LAT:0]         pipe_ext;
   logic [RW-1:0]        row_q, row_d;
   logic [CLW-1:0]       col_q, col_d;

   logic                 push, pop, beat, can_issue, all_issued, last_elem;
   logic [ROW_BITS-1:0]  fifo_dout;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_empty, fifo_full;
   logic [MAX_ROW_BITS-1:0]  head_ext;
   logic [MAX_ELEM_BITS-1:0] head_elem;
   logic                 unused_bits;

   result_row_fifo #(
      .WIDTH (ROW_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (mem_rd_data[ROW_BITS-1:0]),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Handshake, credit and return-path qualifiers.
   always_comb begin
      beat       = !fifo_empty && out_ready;
      last_elem  = (row_q == RW'(ROWS - 1)) && (col_q == CLW'(COLS - 1));
      pop        = beat && (col_q == CLW'(COLS - 1));
      push       = pipe_q[LAT-1];
      can_issue  = (32'(in_flight_q) + 32'(fifo_count)) < FIFO_DEPTH;
      all_issued = (rd_row_q == ISSUE_W'(ROWS));
   end

   // Control FSM and read issue; the first row is requested on the start edge
   // so the first element lands MEM_ACCESS_LATENCY+2 cycles after start.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      base_d   = base_q;
      rd_row_d = rd_row_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_READ;
               busy_d   = 1'b1;
               base_d   = base_addr;
               rd_row_d = '0;
               if (can_issue) begin
                  rd_en_d  = 1'b1;
                  addr_d   = base_addr;
                  rd_row_d = ISSUE_W'(1);
               end
            end
         end
         ST_READ: begin
            if (all_issued) begin
               state_d = ST_DRAIN;
            end else if (can_issue) begin
               rd_en_d  = 1'b1;
               addr_d   = base_q + 32'(rd_row_q);
               rd_row_d = rd_row_q + ISSUE_W'(1);
               if (rd_row_q == ISSUE_W'(ROWS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (beat && last_elem) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_flight_d = in_flight_q + CNT_W'(rd_en_d) - CNT_W'(push);
   end

   // Latency pipe: one valid bit per outstanding read, exits as the data arrives.
   always_comb begin
      pipe_ext = {pipe_q, rd_en_q};
      pipe_d   = pipe_ext[LAT-1:0];
   end

   // Serialiser indices advance on each accepted element.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (beat) begin
         if (col_q == CLW'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CLW'(1);
         end
      end
   end

   // Head-of-FIFO element selection.
   always_comb begin
      head_ext  = MAX_ROW_BITS'(fifo_dout);
      head_elem = extract_elem(head_ext, 32'(col_q), WORD_SIZE);
   end

   // State registers; reset also clears in-flight tracking so late returns are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         base_q      <= '0;
         rd_row_q    <= '0;
         in_flight_q <= '0;
         pipe_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         rd_row_q    <= rd_row_d;
         in_flight_q <= in_flight_d;
         pipe_q      <= pipe_d;
         row_q       <= row_d;
         col_q       <= col_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_en   = rd_en_q;
   assign mem_addr    = addr_q;
   assign out_valid   = !fifo_empty;
   assign out_data    = fifo_empty ? '0 : head_elem[WORD_SIZE-1:0];
   assign out_row     = row_q;
   assign out_col     = col_q;
   assign out_last    = !fifo_empty && last_elem;
   assign unused_bits = ^{head_elem, pipe_ext, mem_rd_data, fifo_full};

endmodule

// File: tb/tb_matmul_result_reader.sv
// Directed bench for matmul_result_reader: four instances cover latency 2/1/5
// on a 4x4 matrix and a 1x1 matrix; one is selected at a time.
module tb_matmul_result_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, out_ready;
   logic [31:0] base_addr;
   int unsigned sel;
   int unsigned errors = 0;
   int unsigned checks = 0;

   int unsigned rows_of [4] = '{4, 4, 4, 1};
   int unsigned cols_of [4] = '{4, 4, 4, 1};
   int unsigned lat_of  [4] = '{2, 1, 5, 2};

   // Per-instance nets
   logic        a_busy, a_done, a_rd_en, a_valid, a_last;
   logic [31:0] a_addr, a_rdata;
   logic [7:0]  a_data;
   logic [1:0]  a_row, a_col;
   logic        b_busy, b_done, b_rd_en, b_valid, b_last;
   logic [31:0] b_addr, b_rdata;
   logic [7:0]  b_data;
   logic [1:0]  b_row, b_col;
   logic        c_busy, c_done, c_rd_en, c_valid, c_last;
   logic [31:0] c_addr, c_rdata;
   logic [7:0]  c_data;
   logic [1:0]  c_row, c_col;
   logic        d_busy, d_done, d_rd_en, d_valid, d_last;
   logic [31:0] d_addr, d_rdata;
   logic [7:0]  d_data;
   logic [0:0]  d_row, d_col;

   logic a_start, b_start, c_start, d_start;
   assign a_start = start && (sel == 0);
   assign b_start = start && (sel == 1);
   assign c_start = start && (sel == 2);
   assign d_start = start && (sel == 3);

   // RAM contents: 0x10.. holds 16r+c, 0x40.. holds 0x80+16r+c.
   function automatic logic [7:0] ram_elem(input logic [31:0] a, input int unsigned c);
      if (a >= 32'h10 && a <= 32'h13) return 8'((a - 32'h10) * 16 + c);
      if (a >= 32'h40 && a <= 32'h43) return 8'(32'h80 + (a - 32'h40) * 16 + c);
      return 8'hEE;
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      logic [31:0] w;
      for (int c = 0; c < 4; c++) w[c*8 +: 8] = ram_elem(a, c);
      return w;
   endfunction

   // RAM latency models; non-read cycles carry a poison pattern.
   logic [31:0] dly_a [2];
   logic [31:0] dly_b [1];
   logic [31:0] dly_c [5];
   logic [31:0] dly_d [2];
   always @(posedge clk) begin
      dly_a[0] <= a_rd_en ? ram_word(a_addr) : 32'hDEAD_BEEF;
      dly_a[1] <= dly_a[0];
      dly_b[0] <= b_rd_en ? ram_word(b_addr) : 32'hDEAD_BEEF;
      dly_c[0] <= c_rd_en ? ram_word(c_addr) : 32'hDEAD_BEEF;
      for (int i = 1; i < 5; i++) dly_c[i] <= dly_c[i-1];
      dly_d[0] <= d_rd_en ? ram_word(d_addr) : 32'hDEAD_BEEF;
      dly_d[1] <= dly_d[0];
   end
   assign a_rdata = dly_a[1];
   assign b_rdata = dly_b[0];
   assign c_rdata = dly_c[4];
   assign d_rdata = dly_d[1];

   matmul_result_reader #(.ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(32),
                          .MEM_ACCESS_LATENCY(2)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .base_addr(base_addr), .busy(a_busy),
      .done(a_done), .mem_addr(a_addr), .mem_rd_en(a_rd_en), .mem_rd_data(a_rdata),
      .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_row(a_row),
      .out_col(a_col), .out_last(a_last));

   matmul_result_reader #(.ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(32),
                          .MEM_ACCESS_LATENCY(1)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .base_addr(base_addr), .busy(b_busy),
      .done(b_done), .mem_addr(b_addr), .mem_rd_en(b_rd_en), .mem_rd_data(b_rdata),
      .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_row(b_row),
      .out_col(b_col), .out_last(b_last));

   matmul_result_reader #(.ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(32),
                          .MEM_ACCESS_LATENCY(5)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .base_addr(base_addr), .busy(c_busy),
      .done(c_done), .mem_addr(c_addr), .mem_rd_en(c_rd_en), .mem_rd_data(c_rdata),
      .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data), .out_row(c_row),
      .out_col(c_col), .out_last(c_last));

   matmul_result_reader #(.ROWS(1), .COLS(1), .WORD_SIZE(8), .MEM_PORT_WIDTH(32),
                          .MEM_ACCESS_LATENCY(2)) u_d (
      .clk(clk), .rst(rst), .start(d_start), .base_addr(base_addr), .busy(d_busy),
      .done(d_done), .mem_addr(d_addr), .mem_rd_en(d_rd_en), .mem_rd_data(d_rdata),
      .out_valid(d_valid), .out_ready(out_ready), .out_data(d_data), .out_row(d_row),
      .out_col(d_col), .out_last(d_last));

   // Observed outputs of the selected instance
   logic        o_busy, o_done, o_rd_en, o_valid, o_last;
   logic [31:0] o_addr;
   logic [7:0]  o_data;
   logic [1:0]  o_row, o_col;
   always_comb begin
      case (sel)
         0: {o_busy, o_done, o_rd_en, o_valid, o_last, o_addr, o_data, o_row, o_col} =
            {a_busy, a_done, a_rd_en, a_valid, a_last, a_addr, a_data, a_row, a_col};
         1: {o_busy, o_done, o_rd_en, o_valid, o_last, o_addr, o_data, o_row, o_col} =
            {b_busy, b_done, b_rd_en, b_valid, b_last, b_addr, b_data, b_row, b_col};
         2: {o_busy, o_done, o_rd_en, o_valid, o_last, o_addr, o_data, o_row, o_col} =
            {c_busy, c_done, c_rd_en, c_valid, c_last, c_addr, c_data, c_row, c_col};
         default: {o_busy, o_done, o_rd_en, o_valid, o_last, o_addr, o_data, o_row, o_col} =
            {d_busy, d_done, d_rd_en, d_valid, d_last, d_addr, d_data, 1'b0, d_row, 1'b0, d_col};
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},  64'(o_busy),  64'(0));
      chk({tag, "_done"},  64'(o_done),  64'(0));
      chk({tag, "_rd_en"}, 64'(o_rd_en), 64'(0));
      chk({tag, "_addr"},  64'(o_addr),  64'(0));
      chk({tag, "_valid"}, 64'(o_valid), 64'(0));
      chk({tag, "_last"},  64'(o_last),  64'(0));
      chk({tag, "_data"},  64'(o_data),  64'(0));
      chk({tag, "_row"},   64'(o_row),   64'(0));
      chk({tag, "_col"},   64'(o_col),   64'(0));
   endtask

   // Start a read-out on instance s and consume it.
   // mode: 0 ready always, 1 random ready, 2 ready held low for 50 cycles.
   task automatic run_drain(input int unsigned s, input logic [31:0] base,
                            input int unsigned mode, input bit poke);
      int unsigned rows, cols, lat, depth, total;
      int unsigned nreads, rows_done, beats;
      bit          seen_first, prev_stall, r;
      logic [7:0]  prev_data;
      rows = rows_of[s]; cols = cols_of[s]; lat = lat_of[s]; depth = lat + 1;
      total = rows * cols;
      nreads = 0; rows_done = 0; beats = 0; seen_first = 0; prev_stall = 0; prev_data = '0;
      sel = s; base_addr = base; start = 1'b1;
      for (int unsigned cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0;
            base_addr = 32'hFFFF_FFF0;
            chk("busy_after_start", 64'(o_busy), 64'(1));
         end
         if (poke && cyc == 3) begin start = 1'b1; base_addr = 32'h40; end
         if (poke && cyc == 4) start = 1'b0;
         if (o_rd_en) begin
            chk("rd_addr", 64'(o_addr), 64'(base + nreads));
            nreads++;
            chk("credit_limit", 64'(nreads <= rows_done + depth), 64'(1));
         end
         if (mode == 2 && cyc == 50) chk("stall_reads", 64'(nreads), 64'(depth));
         if (prev_stall) begin
            chk("stall_valid", 64'(o_valid), 64'(1));
            chk("stall_hold",  64'(o_data),  64'(prev_data));
         end
         if (mode == 0)      r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else                r = (cyc >= 50);
         out_ready = r;
         if (o_valid) begin
            if (!seen_first) begin
               chk("first_latency", 64'(cyc), 64'(lat + 2));
               seen_first = 1;
            end
            chk("data", 64'(o_data), 64'(ram_elem(base + beats / cols, beats % cols)));
            chk("row",  64'(o_row),  64'(beats / cols));
            chk("col",  64'(o_col),  64'(beats % cols));
            chk("last", 64'(o_last), 64'(beats == total - 1));
            prev_stall = !r;
            prev_data  = o_data;
            if (r) begin
               if (beats % cols == cols - 1) rows_done++;
               beats++;
               if (beats == total) break;
            end
         end else begin
            prev_stall = 0;
         end
      end
      chk("beat_count", 64'(beats), 64'(total));
      @(negedge clk);
      chk("done_pulse", 64'(o_done),  64'(1));
      chk("busy_drop",  64'(o_busy),  64'(0));
      chk("empty_end",  64'(o_valid), 64'(0));
      chk("read_count", 64'(nreads),  64'(rows));
      if (poke) begin start = 1'b1; base_addr = 32'h40; end
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 64'(o_done),  64'(0));
      chk("idle_busy",      64'(o_busy),  64'(0));
      chk("idle_rd_en",     64'(o_rd_en), 64'(0));
      out_ready = 1'b1;
   endtask

   initial begin
      bit any_valid;
      int unsigned n;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; sel = 0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      run_drain(0, 32'h10, 0, 0);
      run_drain(0, 32'h10, 1, 0);
      run_drain(0, 32'h10, 2, 0);

      // Abort with two reads outstanding, then restart on a different matrix.
      sel = 0; base_addr = 32'h10; out_ready = 1'b1; start = 1'b1;
      n = 0;
      for (int unsigned cyc = 0; cyc < 10 && n < 2; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (o_rd_en) n++;
      end
      chk("reads_before_abort", 64'(n), 64'(2));
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("abort");
      rst = 1'b0;
      any_valid = 0;
      repeat (8) begin
         @(negedge clk);
         if (o_valid || o_rd_en || o_busy) any_valid = 1;
      end
      chk("no_stale_after_abort", 64'(any_valid), 64'(0));
      run_drain(0, 32'h40, 0, 0);

      // Start pulses while busy and in the done cycle are ignored.
      run_drain(0, 32'h10, 0, 1);

      run_drain(1, 32'h10, 0, 0);
      run_drain(2, 32'h10, 1, 0);
      run_drain(3, 32'h12, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
